// File: rtl/ac_motor_pkg.sv
// Shared constants and helpers for the gate-side AC motor switch monitor:
// space-vector codes, fault bit positions and sector decoding.
package ac_motor_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 15;
    localparam int unsigned DELAY_W_DEFAULT = 11;

    // Vector code is {p1,p2,p3}, 1 = upper switch conducting
    localparam logic [2:0] V0 = 3'b000;
    localparam logic [2:0] V1 = 3'b100;
    localparam logic [2:0] V2 = 3'b110;
    localparam logic [2:0] V3 = 3'b010;
    localparam logic [2:0] V4 = 3'b011;
    localparam logic [2:0] V5 = 3'b001;
    localparam logic [2:0] V6 = 3'b101;
    localparam logic [2:0] V7 = 3'b111;

    localparam int unsigned FAULT_SHOOT   = 0;
    localparam int unsigned FAULT_DEAD    = 1;
    localparam int unsigned FAULT_PATTERN = 2;

    // Position of an active vector on the hexagon (1..6), 0 for zero vectors
    function automatic logic [2:0] vec_index(input logic [2:0] v);
        logic [2:0] idx;
        case (v)
            V1:      idx = 3'd1;
            V2:      idx = 3'd2;
            V3:      idx = 3'd3;
            V4:      idx = 3'd4;
            V5:      idx = 3'd5;
            V6:      idx = 3'd6;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] next_index(input logic [2:0] idx);
        return (idx == 3'd6) ? 3'd1 : idx + 3'd1;
    endfunction

    // Sector of an active pair; vb == V0 means only va was seen. 0 = not a valid sector.
    function automatic logic [2:0] sector_lookup(input logic [2:0] va, input logic [2:0] vb);
        logic [2:0] ia;
        logic [2:0] ib;
        logic [2:0] sec;
        ia  = vec_index(va);
        ib  = vec_index(vb);
        sec = 3'd0;
        if (ia != 3'd0) begin
            if (vb == V0) begin
                sec = ia;
            end else if ((ib != 3'd0) && (ib == next_index(ia))) begin
                sec = ia;
            end else if ((ib != 3'd0) && (ia == next_index(ib))) begin
                sec = ib;
            end
        end
        return sec;
    endfunction

endpackage

// File: rtl/ac_motor_dead_time_check.sv
// Per-phase checker: holds the phase state through dead time, counts
// consecutive both-off cycles and flags shoot-through / short dead time.
module ac_motor_dead_time_check
    import ac_motor_pkg::*;
#(
    parameter int unsigned DELAY_W = DELAY_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [DELAY_W-1:0] i_delay,
    input  logic               i_high,
    input  logic               i_low,
    output logic               o_state_c,
    output logic               o_shoot_c,
    output logic               o_dead_c
);

    logic               r_state;
    logic               r_prev_high;
    logic               r_prev_low;
    logic [DELAY_W-1:0] r_off_cnt;

    logic w_high_on;
    logic w_low_on;
    logic w_both_off;
    logic w_turn_on;

    assign w_high_on  = i_high & ~i_low;
    assign w_low_on   = i_low & ~i_high;
    assign w_both_off = ~i_high & ~i_low;

    // A side turning on is one that conducts alone now and did not conduct last cycle
    assign w_turn_on = (w_high_on & ~r_prev_high) | (w_low_on & ~r_prev_low);

    assign o_state_c = w_high_on ? 1'b1 : (w_low_on ? 1'b0 : r_state);
    assign o_shoot_c = i_enable & i_high & i_low;
    assign o_dead_c  = i_enable & w_turn_on & (r_off_cnt < i_delay);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= 1'b0;
            r_prev_high <= 1'b0;
            r_prev_low  <= 1'b0;
            r_off_cnt   <= '0;
        end else begin
            r_state     <= o_state_c;
            r_prev_high <= i_high;
            r_prev_low  <= i_low;
            if (w_both_off) begin
                if (r_off_cnt != '1) begin
                    r_off_cnt <= r_off_cnt + DELAY_W'(1);
                end
            end else begin
                r_off_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ac_motor_switch_monitor.sv
// Gate-side monitor: checks the six inverter gate signals for shoot-through and
// dead-time faults, and decodes each PWM period into sector and t1/t2/t0 dwell.
module ac_motor_switch_monitor
    import ac_motor_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned DELAY_W = DELAY_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [DELAY_W-1:0] delay,
    input  logic               s1_high,
    input  logic               s1_low,
    input  logic               s2_high,
    input  logic               s2_low,
    input  logic               s3_high,
    input  logic               s3_low,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic               valid,
    output logic [2:0]         sector,
    output logic [CNT_W-1:0]   t1_meas,
    output logic [CNT_W-1:0]   t2_meas,
    output logic [CNT_W-1:0]   t0_meas
);

    localparam logic [0:0] S_IDLE_FIRST = 1'b0;
    localparam logic [0:0] S_MEASURE    = 1'b1;

    logic [2:0]       r_high;
    logic [2:0]       r_low;
    logic [2:0]       r_prev_sv;
    logic [0:0]       r_fsm;
    logic [CNT_W-1:0] r_t1;
    logic [CNT_W-1:0] r_t2;
    logic [CNT_W-1:0] r_t0;
    logic [2:0]       r_v1;
    logic [2:0]       r_v2;
    logic             r_third;
    logic             r_valid;
    logic [2:0]       r_sector;
    logic [CNT_W-1:0] r_t1_meas;
    logic [CNT_W-1:0] r_t2_meas;
    logic [CNT_W-1:0] r_t0_meas;
    logic [2:0]       r_fault_code;
    logic             r_fault;

    logic [2:0] w_sv;
    logic [2:0] w_shoot;
    logic [2:0] w_dead;
    logic       w_zero_entry;
    logic       w_is_zero;
    logic [0:0] w_fsm_nxt;
    logic       w_publish;
    logic       w_start;
    logic [2:0] w_sector;
    logic       w_pattern_bad;
    logic [2:0] w_fault_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + CNT_W'(1);
    endfunction

    // Bit 2 carries phase 1 so that the vector reads {p1,p2,p3}
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_high <= '0;
            r_low  <= '0;
        end else begin
            r_high <= {s1_high, s2_high, s3_high};
            r_low  <= {s1_low, s2_low, s3_low};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_phase
        ac_motor_dead_time_check #(
            .DELAY_W (DELAY_W)
        ) u_check (
            .clk       (clk),
            .rst_n     (reset_n),
            .i_enable  (enable),
            .i_delay   (delay),
            .i_high    (r_high[g]),
            .i_low     (r_low[g]),
            .o_state_c (w_sv[g]),
            .o_shoot_c (w_shoot[g]),
            .o_dead_c  (w_dead[g])
        );
    end

    assign w_zero_entry  = (w_sv == V0) && (r_prev_sv != V0);
    assign w_is_zero     = (w_sv == V0) || (w_sv == V7);
    assign w_sector      = r_third ? 3'd0 : sector_lookup(r_v1, r_v2);
    assign w_pattern_bad = (w_sector == 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm     <= S_IDLE_FIRST;
            r_prev_sv <= V0;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_prev_sv <= w_sv;
        end
    end

    // Window FSM: the first window after reset or enable rise only arms measurement
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_publish = 1'b0;
        w_start   = 1'b0;
        if (!enable) begin
            w_fsm_nxt = S_IDLE_FIRST;
        end else begin
            case (r_fsm)
                S_IDLE_FIRST: begin
                    if (w_zero_entry) begin
                        w_fsm_nxt = S_MEASURE;
                        w_start   = 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (w_zero_entry) begin
                        w_publish = 1'b1;
                        w_start   = 1'b1;
                    end
                end
                default: w_fsm_nxt = S_IDLE_FIRST;
            endcase
        end
    end

    // Dwell counters; the window-closing cycle is the first t0 cycle of the next window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t1    <= '0;
            r_t2    <= '0;
            r_t0    <= '0;
            r_v1    <= V0;
            r_v2    <= V0;
            r_third <= 1'b0;
        end else if (!enable) begin
            r_t1    <= '0;
            r_t2    <= '0;
            r_t0    <= '0;
            r_v1    <= V0;
            r_v2    <= V0;
            r_third <= 1'b0;
        end else if (w_start) begin
            r_t1    <= '0;
            r_t2    <= '0;
            r_t0    <= CNT_W'(1);
            r_v1    <= V0;
            r_v2    <= V0;
            r_third <= 1'b0;
        end else if (r_fsm == S_MEASURE) begin
            if (w_is_zero) begin
                r_t0 <= sat_inc(r_t0);
            end else if (r_v1 == V0) begin
                r_v1 <= w_sv;
                r_t1 <= CNT_W'(1);
            end else if (w_sv == r_v1) begin
                r_t1 <= sat_inc(r_t1);
            end else if (r_v2 == V0) begin
                r_v2 <= w_sv;
                r_t2 <= CNT_W'(1);
            end else if (w_sv == r_v2) begin
                r_t2 <= sat_inc(r_t2);
            end else begin
                r_third <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_sector  <= 3'd0;
            r_t1_meas <= '0;
            r_t2_meas <= '0;
            r_t0_meas <= '0;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_sector  <= w_sector;
                r_t1_meas <= r_t1;
                r_t2_meas <= r_t2;
                r_t0_meas <= r_t0;
            end
        end
    end

    // Sticky faults: a fault seen in the clearing cycle survives the clear
    always_comb begin
        w_fault_nxt                = clear ? 3'b000 : r_fault_code;
        w_fault_nxt[FAULT_SHOOT]   = w_fault_nxt[FAULT_SHOOT] | (|w_shoot);
        w_fault_nxt[FAULT_DEAD]    = w_fault_nxt[FAULT_DEAD] | (|w_dead);
        w_fault_nxt[FAULT_PATTERN] = w_fault_nxt[FAULT_PATTERN] | (w_publish & w_pattern_bad);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault_code <= 3'b000;
            r_fault      <= 1'b0;
        end else begin
            r_fault_code <= w_fault_nxt;
            r_fault      <= |w_fault_nxt;
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign valid      = r_valid;
    assign sector     = r_sector;
    assign t1_meas    = r_t1_meas;
    assign t2_meas    = r_t2_meas;
    assign t0_meas    = r_t0_meas;

endmodule

// File: tb/tb_ac_motor_switch_monitor.sv
// Randomized bench for ac_motor_switch_monitor against a cycle-level
// behavioural model of the gate rules, windows and sticky faults.
module tb_ac_motor_switch_monitor;

    localparam int CMAX = 32767;
    localparam int DMAX = 2047;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic [10:0] delay;
    logic [2:0]  g_h;
    logic [2:0]  g_l;
    logic        fault;
    logic [2:0]  fault_code;
    logic        valid;
    logic [2:0]  sector;
    logic [14:0] t1_meas;
    logic [14:0] t2_meas;
    logic [14:0] t0_meas;

    always #5 clk = ~clk;

    ac_motor_switch_monitor dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .delay      (delay),
        .s1_high    (g_h[2]),
        .s1_low     (g_l[2]),
        .s2_high    (g_h[1]),
        .s2_low     (g_l[1]),
        .s3_high    (g_h[0]),
        .s3_low     (g_l[0]),
        .fault      (fault),
        .fault_code (fault_code),
        .valid      (valid),
        .sector     (sector),
        .t1_meas    (t1_meas),
        .t2_meas    (t2_meas),
        .t0_meas    (t0_meas)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hexagon order of active vectors V1..V6
    bit [2:0] ring [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    // ---------------- reference model ----------------
    bit [2:0] mp_h, mp_l;          // gate values the DUT input stage holds
    bit [2:0] m_was_h, m_was_l;    // gate values one cycle earlier
    int       m_off [3];
    bit [2:0] m_ph;
    bit [2:0] m_prev_sv;
    bit       m_armed;
    bit [2:0] m_seen [$];
    int       m_dwell [8];
    int       m_t0;
    bit [2:0] m_fc;
    bit       e_valid;
    int       e_sector, e_t1, e_t2, e_t0;

    function automatic int clip(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic int vpos(input bit [2:0] v);
        for (int i = 0; i < 6; i++) if (ring[i] == v) return i + 1;
        return 0;
    endfunction

    task automatic window_clear();
        m_seen.delete();
        for (int i = 0; i < 8; i++) m_dwell[i] = 0;
        m_t0 = 0;
    endtask

    task automatic model_reset();
        mp_h = 0; mp_l = 0; m_was_h = 0; m_was_l = 0;
        for (int j = 0; j < 3; j++) m_off[j] = 0;
        m_ph = 0; m_prev_sv = 0; m_armed = 0; m_fc = 0;
        window_clear();
        e_valid = 0; e_sector = 0; e_t1 = 0; e_t2 = 0; e_t0 = 0;
    endtask

    task automatic publish(inout bit [2:0] newf);
        int sec, a, b;
        sec = 0;
        if (m_seen.size() == 1) sec = vpos(m_seen[0]);
        else if (m_seen.size() == 2) begin
            a = vpos(m_seen[0]);
            b = vpos(m_seen[1]);
            if ((a % 6) + 1 == b) sec = a;
            else if ((b % 6) + 1 == a) sec = b;
        end
        if (sec == 0) newf[2] = 1'b1;
        e_valid  = 1'b1;
        e_sector = sec;
        e_t1     = (m_seen.size() > 0) ? clip(m_dwell[m_seen[0]]) : 0;
        e_t2     = (m_seen.size() > 1) ? clip(m_dwell[m_seen[1]]) : 0;
        e_t0     = clip(m_t0);
    endtask

    task automatic model_step(input bit [2:0] h, input bit [2:0] l, input bit en, input bit clr, input int dly);
        bit [2:0] newf;
        bit [2:0] sv;
        bit       on_h, on_l, known;
        newf = 0;
        for (int j = 0; j < 3; j++) begin
            on_h = h[j] && !l[j];
            on_l = l[j] && !h[j];
            if (en && h[j] && l[j]) newf[0] = 1'b1;
            if (en && ((on_h && !m_was_h[j]) || (on_l && !m_was_l[j])) && (m_off[j] < dly)) newf[1] = 1'b1;
            m_off[j] = (!h[j] && !l[j]) ? ((m_off[j] < DMAX) ? m_off[j] + 1 : DMAX) : 0;
            if (on_h) m_ph[j] = 1'b1;
            else if (on_l) m_ph[j] = 1'b0;
        end
        m_was_h = h;
        m_was_l = l;
        sv = m_ph;
        e_valid = 1'b0;
        if (!en) begin
            m_armed = 0;
            window_clear();
        end else if (sv == 3'b000 && m_prev_sv != 3'b000) begin
            if (m_armed) publish(newf);
            m_armed = 1;
            window_clear();
            m_t0 = 1;
        end else if (m_armed) begin
            if (sv == 3'b000 || sv == 3'b111) m_t0++;
            else begin
                known = 0;
                foreach (m_seen[i]) if (m_seen[i] == sv) known = 1;
                if (!known) m_seen.push_back(sv);
                m_dwell[sv]++;
            end
        end
        m_prev_sv = sv;
        m_fc = (clr ? 3'b000 : m_fc) | newf;
    endtask

    // ---------------- stimulus ----------------
    bit [2:0] cur_vec;

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset_n) model_reset();
        else model_step(mp_h, mp_l, enable, clear, int'(delay));
        if (reset_n) begin mp_h = g_h; mp_l = g_l; end
        else begin mp_h = 0; mp_l = 0; end
        chk("valid", int'(valid), int'(e_valid));
        chk("fault_code", int'(fault_code), int'(m_fc));
        chk("fault", int'(fault), int'(|m_fc));
        chk("sector", int'(sector), e_sector);
        chk("t1_meas", int'(t1_meas), e_t1);
        chk("t2_meas", int'(t2_meas), e_t2);
        chk("t0_meas", int'(t0_meas), e_t0);
    endtask

    task automatic drive(input bit [2:0] v, input bit [2:0] off);
        for (int j = 0; j < 3; j++) begin
            g_h[j] = off[j] ? 1'b0 : v[j];
            g_l[j] = off[j] ? 1'b0 : ~v[j];
        end
    endtask

    // Phases that change go dead for 'dead' cycles, then the new vector holds 'hold' cycles
    task automatic go_vec(input bit [2:0] v, input int dead, input int hold);
        for (int i = 0; i < dead; i++) begin drive(cur_vec, v ^ cur_vec); tick(); end
        cur_vec = v;
        drive(v, 3'b000);
        for (int i = 0; i < hold; i++) tick();
    endtask

    task automatic period(input bit [2:0] va, input bit [2:0] vb, input int tz, input int ta,
                          input int tb, input int t7, input int dz, input int da, input int db, input int d7);
        go_vec(3'b000, dz, tz);
        go_vec(va, da, ta);
        go_vec(vb, db, tb);
        go_vec(3'b111, d7, t7);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; delay = 11'd20;
        cur_vec = 3'b000; drive(3'b000, 3'b000);
        model_reset();
        #2;
        chk("rst_fault", int'(fault), 0);
        chk("rst_valid", int'(valid), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        enable = 1'b1;

        // Clean sector-1 periods: V1 300, V2 200, zero 100+100
        repeat (4) period(3'b100, 3'b110, 75, 275, 175, 75, 25, 25, 25, 25);
        chk("clean_sector", int'(sector), 1);
        chk("clean_t1", int'(t1_meas), 300);
        chk("clean_t2", int'(t2_meas), 200);
        chk("clean_t0", int'(t0_meas), 200);
        chk("clean_fault", int'(fault_code), 0);

        // Phase-2 edge one cycle short of the delay
        period(3'b100, 3'b110, 75, 275, 175, 75, 25, 25, 19, 25);
        chk("dead_flag", int'(fault_code), 3'b010);
        period(3'b100, 3'b110, 75, 275, 175, 75, 25, 25, 25, 25);
        chk("dead_sticky", int'(fault_code), 3'b010);
        pulse_clear();
        tick();
        chk("dead_cleared", int'(fault_code), 0);

        // Shoot-through on phase 3 with clear landing in the flag cycle
        g_h[0] = 1'b1; g_l[0] = 1'b1; tick();
        drive(cur_vec, 3'b000);
        pulse_clear();
        chk("shoot_kept", int'(fault_code[0]), 1);
        tick();
        pulse_clear();
        tick();
        chk("shoot_cleared", int'(fault_code), 0);

        // Non-adjacent pair V1 then V3
        go_vec(3'b000, 25, 75);
        go_vec(3'b100, 25, 100);
        go_vec(3'b010, 25, 100);
        go_vec(3'b000, 25, 50);
        chk("pat_sector", int'(sector), 0);
        chk("pat_flag", int'(fault_code[2]), 1);
        pulse_clear();

        // Saturation of t1
        go_vec(3'b100, 25, 40000);
        go_vec(3'b000, 25, 50);
        chk("sat_t1", int'(t1_meas), CMAX);
        chk("sat_sector", int'(sector), 1);

        // Reset in the middle of a window
        period(3'b110, 3'b010, 60, 120, 90, 60, 25, 25, 25, 25);
        go_vec(3'b000, 25, 40);
        go_vec(3'b010, 25, 30);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_sector", int'(sector), 0);
        chk("mid_rst_t1", int'(t1_meas), 0);
        chk("mid_rst_fault", int'(fault_code), 0);
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) period(3'b010, 3'b011, 50, 100, 80, 50, 25, 25, 25, 25);

        // Enable low holds measurement idle
        enable = 1'b0;
        repeat (2) period(3'b011, 3'b001, 50, 90, 70, 50, 25, 10, 25, 25);
        enable = 1'b1;
        repeat (3) period(3'b001, 3'b101, 50, 90, 70, 50, 25, 25, 25, 25);

        // Zero delay allows direct complementary switching
        delay = 11'd0;
        repeat (3) period(3'b101, 3'b100, 40, 70, 60, 40, 0, 0, 0, 0);
        delay = 11'd20;
        pulse_clear();

        // Randomized periods, occasional bad pairs, short dead times, shoots and clears
        for (int p = 0; p < 24; p++) begin
            int n;
            bit [2:0] va, vb;
            n  = $urandom_range(5, 0);
            va = ring[n];
            vb = ($urandom_range(3, 0) == 0) ? ring[$urandom_range(5, 0)] : ring[(n + 1) % 6];
            if ($urandom_range(1, 0) == 1) begin
                bit [2:0] tmp;
                tmp = va; va = vb; vb = tmp;
            end
            period(va, vb, $urandom_range(120, 20), $urandom_range(120, 20),
                   $urandom_range(120, 20), $urandom_range(120, 20),
                   $urandom_range(40, 15), $urandom_range(40, 15),
                   $urandom_range(40, 15), $urandom_range(40, 15));
            if ($urandom_range(3, 0) == 0) begin
                int j;
                j = $urandom_range(2, 0);
                g_h[j] = 1'b1; g_l[j] = 1'b1; tick();
                drive(cur_vec, 3'b000);
            end
            if ($urandom_range(2, 0) == 0) pulse_clear();
        end
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
